// File: rtl/dm_pkg.sv
// Debug-module shared definitions: DMI register map, error codes, register layouts.
package dm_pkg;

    // DMI register addresses
    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;

    // Only 32-bit register accesses are supported by the abstract command
    localparam logic [2:0] AARSIZE_32 = 3'd2;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_IDLE   = 2'd0,
        DMI_ACCESS = 2'd1,
        DMI_RESP   = 2'd2
    } dmi_state_e;

    typedef enum logic [1:0] {
        AC_IDLE = 2'd0,
        AC_REQ  = 2'd1,
        AC_WAIT = 2'd2
    } ac_state_e;

    typedef struct packed {
        logic        haltreq;
        logic        resumereq;
        logic [27:0] rsvd;
        logic        ndmreset;
        logic        dmactive;
    } dmcontrol_t;

    typedef struct packed {
        logic [2:0]  rsvd3;
        logic [4:0]  progbufsize;
        logic [10:0] rsvd2;
        logic        busy;
        logic        rsvd1;
        logic [2:0]  cmderr;
        logic [3:0]  rsvd0;
        logic [3:0]  datacount;
    } abstractcs_t;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        rsvd;
        logic [2:0]  aarsize;
        logic        aarpostincrement;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } command_t;

    // Assemble the read-only dmstatus word for a single hart
    function automatic logic [31:0] dmstatus_f(input logic halted, input logic running,
                                               input logic resumeack);
        logic [31:0] v;
        v        = 32'h0000_0000;
        v[3:0]   = 4'd2;
        v[7]     = 1'b1;
        v[8]     = halted;
        v[9]     = halted;
        v[10]    = running;
        v[11]    = running;
        v[16]    = resumeack;
        v[17]    = resumeack;
        return v;
    endfunction

endpackage

// File: rtl/dm_abstract_cmd.sv
// Abstract register-access sequencer: issues one ar_req pulse and waits for ar_done.
module dm_abstract_cmd
    import dm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic        write_i,
    input  logic [15:0] regno_i,
    input  logic [31:0] wdata_i,
    input  logic        ar_done_i,
    output logic        ar_req_o,
    output logic        ar_write_o,
    output logic [15:0] ar_regno_o,
    output logic [31:0] ar_wdata_o,
    output logic        busy_o,
    output logic        rdata_load_o
);

    ac_state_e   state_q, state_d;
    logic        ar_req_q, ar_req_d;
    logic        write_q, write_d;
    logic [15:0] regno_q, regno_d;
    logic [31:0] wdata_q, wdata_d;

    // Next-state and request-field logic; clear_i forces the reset state
    always_comb begin
        state_d  = state_q;
        ar_req_d = 1'b0;
        write_d  = write_q;
        regno_d  = regno_q;
        wdata_d  = wdata_q;
        case (state_q)
            AC_IDLE: begin
                if (start_i) begin
                    state_d  = AC_REQ;
                    ar_req_d = 1'b1;
                    write_d  = write_i;
                    regno_d  = regno_i;
                    wdata_d  = wdata_i;
                end else begin
                    state_d  = AC_IDLE;
                end
            end
            AC_REQ: begin
                state_d = AC_WAIT;
            end
            AC_WAIT: begin
                if (ar_done_i) begin
                    state_d = AC_IDLE;
                end else begin
                    state_d = AC_WAIT;
                end
            end
            default: begin
                state_d = AC_IDLE;
            end
        endcase
        if (clear_i) begin
            state_d  = AC_IDLE;
            ar_req_d = 1'b0;
            write_d  = 1'b0;
            regno_d  = 16'h0000;
            wdata_d  = 32'h0000_0000;
        end else begin
            state_d  = state_d;
        end
    end

    // State and request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= AC_IDLE;
            ar_req_q <= 1'b0;
            write_q  <= 1'b0;
            regno_q  <= 16'h0000;
            wdata_q  <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            ar_req_q <= ar_req_d;
            write_q  <= write_d;
            regno_q  <= regno_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ar_req_o     = ar_req_q;
    assign ar_write_o   = write_q;
    assign ar_regno_o   = regno_q;
    assign ar_wdata_o   = wdata_q;
    assign busy_o       = (state_q != AC_IDLE);
    assign rdata_load_o = (state_q == AC_WAIT) && ar_done_i && !write_q && !clear_i;

endmodule

// File: rtl/dm_dmi_responder.sv
// Debug-module DMI slave: register file, hart run control and abstract command launch.
module dm_dmi_responder
    import dm_pkg::*;
#(
    parameter int unsigned DATACOUNT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmi_start,
    input  logic [1:0]  dmi_op,
    input  logic [6:0]  dmi_address,
    input  logic [31:0] dmi_data_i,
    output logic        dmi_finish,
    output logic [31:0] dmi_data_o,
    output logic        halt_req,
    output logic        resume_req,
    output logic        ndmreset,
    input  logic        hart_halted,
    input  logic        hart_running,
    output logic        ar_req,
    output logic        ar_write,
    output logic [15:0] ar_regno,
    output logic [31:0] ar_wdata,
    input  logic [31:0] ar_rdata,
    input  logic        ar_done
);

    dmi_state_e  dmi_state_q, dmi_state_d;
    dmi_op_e     op_q, op_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        dmi_finish_q, dmi_finish_d;
    logic [31:0] dmi_data_o_q, dmi_data_o_d;
    logic        haltreq_q, haltreq_d;
    logic        ndmreset_q, ndmreset_d;
    logic        dmactive_q, dmactive_d;
    logic        resume_req_q, resume_req_d;
    logic        resumeack_q, resumeack_d;
    logic [31:0] data0_q, data0_d;
    cmderr_e     cmderr_q, cmderr_d;

    logic        ac_start_s;
    logic        ac_clear_s;
    logic        ac_busy_s;
    logic        ac_load_s;
    logic [31:0] rdata_s;
    command_t    cmd_s;
    dmcontrol_t  dmc_w_s;
    abstractcs_t acs_s;
    logic        unused_s;

    assign cmd_s    = wdata_q;
    assign dmc_w_s  = wdata_q;
    assign unused_s = ^{dmc_w_s.rsvd, cmd_s.rsvd, cmd_s.aarpostincrement, cmd_s.postexec};

    // abstractcs read view
    always_comb begin
        acs_s             = '0;
        acs_s.datacount   = 4'(DATACOUNT);
        acs_s.cmderr      = cmderr_q;
        acs_s.busy        = ac_busy_s;
        acs_s.progbufsize = 5'd0;
    end

    // DMI FSM, register read mux and register write side effects
    always_comb begin
        dmi_state_d  = dmi_state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        dmi_finish_d = 1'b0;
        dmi_data_o_d = dmi_data_o_q;
        haltreq_d    = haltreq_q;
        ndmreset_d   = ndmreset_q;
        dmactive_d   = dmactive_q;
        resume_req_d = resume_req_q;
        resumeack_d  = resumeack_q;
        data0_d      = data0_q;
        cmderr_d     = cmderr_q;
        ac_start_s   = 1'b0;
        rdata_s      = 32'h0000_0000;

        // Resume handshake completes once the hart reports running
        if (resume_req_q && hart_running) begin
            resume_req_d = 1'b0;
            resumeack_d  = 1'b1;
        end else begin
            resume_req_d = resume_req_q;
        end

        // Completed abstract read lands in data0
        if (ac_load_s) begin
            data0_d = ar_rdata;
        end else begin
            data0_d = data0_q;
        end

        case (dmi_state_q)
            DMI_IDLE: begin
                if (dmi_start) begin
                    dmi_state_d = DMI_ACCESS;
                    op_d        = dmi_op_e'(dmi_op);
                    addr_d      = dmi_address;
                    wdata_d     = dmi_data_i;
                end else begin
                    dmi_state_d = DMI_IDLE;
                end
            end
            DMI_ACCESS: begin
                dmi_state_d  = DMI_RESP;
                dmi_finish_d = 1'b1;
                case (addr_q)
                    ADDR_DATA0:      rdata_s = data0_q;
                    ADDR_DMCONTROL:  rdata_s = {haltreq_q, 1'b0, 28'h0, ndmreset_q, dmactive_q};
                    ADDR_DMSTATUS:   rdata_s = dmstatus_f(hart_halted, hart_running, resumeack_q);
                    ADDR_ABSTRACTCS: rdata_s = acs_s;
                    default:         rdata_s = 32'h0000_0000;
                endcase
                if (op_q == DMI_OP_READ) begin
                    dmi_data_o_d = rdata_s;
                    if ((addr_q == ADDR_DATA0) && ac_busy_s && (cmderr_q == CMDERR_NONE)) begin
                        cmderr_d = CMDERR_BUSY;
                    end else begin
                        cmderr_d = cmderr_q;
                    end
                end else if (op_q == DMI_OP_WRITE) begin
                    case (addr_q)
                        ADDR_DATA0: begin
                            if (ac_busy_s) begin
                                if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
                            end else if (dmactive_q) begin
                                data0_d = wdata_q;
                            end
                        end
                        ADDR_DMCONTROL: begin
                            dmactive_d = dmc_w_s.dmactive;
                            if (dmactive_q) begin
                                haltreq_d  = dmc_w_s.haltreq;
                                ndmreset_d = dmc_w_s.ndmreset;
                                if (dmc_w_s.resumereq && !dmc_w_s.haltreq) begin
                                    resume_req_d = 1'b1;
                                    resumeack_d  = 1'b0;
                                end
                            end
                        end
                        ADDR_ABSTRACTCS: begin
                            if (ac_busy_s) begin
                                if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
                            end else begin
                                cmderr_d = cmderr_e'(cmderr_q & ~wdata_q[10:8]);
                            end
                        end
                        ADDR_COMMAND: begin
                            if (!dmactive_q) begin
                                cmderr_d = cmderr_q;
                            end else if (ac_busy_s) begin
                                if (cmderr_q == CMDERR_NONE) cmderr_d = CMDERR_BUSY;
                            end else if (cmderr_q != CMDERR_NONE) begin
                                cmderr_d = cmderr_q;
                            end else if ((cmd_s.cmdtype != 8'd0) || (cmd_s.aarsize != AARSIZE_32)) begin
                                cmderr_d = CMDERR_NOTSUP;
                            end else if (!hart_halted) begin
                                cmderr_d = CMDERR_HALTRESUME;
                            end else if (cmd_s.transfer) begin
                                ac_start_s = 1'b1;
                            end
                        end
                        default: begin
                            cmderr_d = cmderr_q;
                        end
                    endcase
                end else begin
                    dmi_data_o_d = dmi_data_o_q;
                end
            end
            DMI_RESP: begin
                dmi_state_d = DMI_IDLE;
            end
            default: begin
                dmi_state_d = DMI_IDLE;
            end
        endcase

        // Inactive debug module pins everything but dmactive at reset values
        if (!dmactive_d) begin
            haltreq_d    = 1'b0;
            ndmreset_d   = 1'b0;
            resume_req_d = 1'b0;
            resumeack_d  = 1'b0;
            data0_d      = 32'h0000_0000;
            cmderr_d     = CMDERR_NONE;
            ac_start_s   = 1'b0;
        end else begin
            dmactive_d   = 1'b1;
        end
    end

    assign ac_clear_s = !dmactive_d;

    // DMI transaction and debug register state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            dmi_state_q  <= DMI_IDLE;
            op_q         <= DMI_OP_NOP;
            addr_q       <= 7'h00;
            wdata_q      <= 32'h0000_0000;
            dmi_finish_q <= 1'b0;
            dmi_data_o_q <= 32'h0000_0000;
            haltreq_q    <= 1'b0;
            ndmreset_q   <= 1'b0;
            dmactive_q   <= 1'b0;
            resume_req_q <= 1'b0;
            resumeack_q  <= 1'b0;
            data0_q      <= 32'h0000_0000;
            cmderr_q     <= CMDERR_NONE;
        end else begin
            dmi_state_q  <= dmi_state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            dmi_finish_q <= dmi_finish_d;
            dmi_data_o_q <= dmi_data_o_d;
            haltreq_q    <= haltreq_d;
            ndmreset_q   <= ndmreset_d;
            dmactive_q   <= dmactive_d;
            resume_req_q <= resume_req_d;
            resumeack_q  <= resumeack_d;
            data0_q      <= data0_d;
            cmderr_q     <= cmderr_d;
        end
    end

    dm_abstract_cmd u_abstract_cmd (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (ac_clear_s),
        .start_i      (ac_start_s),
        .write_i      (cmd_s.write),
        .regno_i      (cmd_s.regno),
        .wdata_i      (data0_q),
        .ar_done_i    (ar_done),
        .ar_req_o     (ar_req),
        .ar_write_o   (ar_write),
        .ar_regno_o   (ar_regno),
        .ar_wdata_o   (ar_wdata),
        .busy_o       (ac_busy_s),
        .rdata_load_o (ac_load_s)
    );

    assign dmi_finish = dmi_finish_q;
    assign dmi_data_o = dmi_data_o_q;
    assign halt_req   = haltreq_q;
    assign resume_req = resume_req_q;
    assign ndmreset   = ndmreset_q;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// Directed bench for dm_dmi_responder with hand-computed expected values.
module tb_dm_dmi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmi_start;
    logic [1:0]  dmi_op;
    logic [6:0]  dmi_address;
    logic [31:0] dmi_data_i;
    logic        dmi_finish;
    logic [31:0] dmi_data_o;
    logic        halt_req, resume_req, ndmreset;
    logic        hart_halted, hart_running;
    logic        ar_req, ar_write;
    logic [15:0] ar_regno;
    logic [31:0] ar_wdata, ar_rdata;
    logic        ar_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] rd;
    int          cnt;

    dm_dmi_responder #(.DATACOUNT(1)) dut (
        .clk(clk), .rst(rst), .dmi_start(dmi_start), .dmi_op(dmi_op),
        .dmi_address(dmi_address), .dmi_data_i(dmi_data_i), .dmi_finish(dmi_finish),
        .dmi_data_o(dmi_data_o), .halt_req(halt_req), .resume_req(resume_req),
        .ndmreset(ndmreset), .hart_halted(hart_halted), .hart_running(hart_running),
        .ar_req(ar_req), .ar_write(ar_write), .ar_regno(ar_regno), .ar_wdata(ar_wdata),
        .ar_rdata(ar_rdata), .ar_done(ar_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One DMI transaction; returns at the falling edge where dmi_finish is seen
    task automatic dmi_xfer(input logic [1:0] op, input logic [6:0] addr,
                            input logic [31:0] data, output logic [31:0] rdata);
        int lat;
        @(posedge clk); #1;
        dmi_start = 1'b1; dmi_op = op; dmi_address = addr; dmi_data_i = data;
        @(posedge clk); #1;
        dmi_start = 1'b0; dmi_op = 2'd0; dmi_address = 7'h00; dmi_data_i = 32'h0;
        lat = 1;
        rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (dmi_finish === 1'b1) break;
            if (lat >= 10) break;
            @(posedge clk); #1;
            lat++;
        end
        if (dmi_finish !== 1'b1) check_val("dmi_finish_timeout", {31'h0, dmi_finish}, 32'h1);
        else check_val("dmi_latency", lat, 32'd2);
        rdata = dmi_data_o;
    endtask

    task automatic pulse_done(input logic [31:0] data);
        @(posedge clk); #1;
        ar_done = 1'b1; ar_rdata = data;
        @(posedge clk); #1;
        ar_done = 1'b0; ar_rdata = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check_val({tag, "_finish"}, {31'h0, dmi_finish}, 32'h0);
        check_val({tag, "_data_o"}, dmi_data_o, 32'h0);
        check_val({tag, "_ctrl"}, {29'h0, halt_req, resume_req, ndmreset}, 32'h0);
        check_val({tag, "_ar"}, {15'h0, ar_req, ar_write, ar_regno}, 32'h0);
        check_val({tag, "_ar_wdata"}, ar_wdata, 32'h0);
    endtask

    initial begin
        rst = 1'b1; dmi_start = 1'b0; dmi_op = 2'd0; dmi_address = 7'h00; dmi_data_i = 32'h0;
        hart_halted = 1'b0; hart_running = 1'b1; ar_rdata = 32'h0; ar_done = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1; rst = 1'b0;

        // dmactive then dmstatus
        dmi_xfer(2'd2, 7'h10, 32'h0000_0001, rd);
        dmi_xfer(2'd1, 7'h11, 32'h0, rd);
        check_val("dmstatus_running", rd, 32'h0000_0C82);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("abstractcs_idle", rd, 32'h0000_0001);
        dmi_xfer(2'd1, 7'h20, 32'h0, rd);
        check_val("unmapped_read", rd, 32'h0);

        // nop op completes without changing registers
        dmi_xfer(2'd0, 7'h10, 32'h8000_0003, rd);
        dmi_xfer(2'd1, 7'h10, 32'h0, rd);
        check_val("nop_no_effect", rd, 32'h0000_0001);

        // haltreq
        dmi_xfer(2'd2, 7'h10, 32'h8000_0001, rd);
        check_val("halt_req_set", {31'h0, halt_req}, 32'h1);
        dmi_xfer(2'd1, 7'h10, 32'h0, rd);
        check_val("dmcontrol_halt", rd, 32'h8000_0001);

        // resumereq handshake
        hart_running = 1'b0;
        dmi_xfer(2'd2, 7'h10, 32'h4000_0001, rd);
        cnt = (resume_req === 1'b1) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 1) hart_running = 1'b1;
            @(negedge clk);
            if (resume_req === 1'b1) cnt++;
            else break;
        end
        check_val("resume_req_cycles", cnt, 32'd3);
        dmi_xfer(2'd1, 7'h11, 32'h0, rd);
        check_val("dmstatus_resumeack", rd, 32'h0003_0C82);
        dmi_xfer(2'd1, 7'h10, 32'h0, rd);
        check_val("resumereq_reads_0", rd, 32'h0000_0001);

        // abstract read of regno 0x1001 on a halted hart
        hart_halted = 1'b1; hart_running = 1'b0;
        dmi_xfer(2'd2, 7'h04, 32'h1234_5678, rd);
        dmi_xfer(2'd2, 7'h17, 32'h0022_1001, rd);
        check_val("ar_req_pulse", {31'h0, ar_req}, 32'h1);
        check_val("ar_fields", {15'h0, ar_write, ar_regno}, 32'h0000_1001);
        check_val("ar_wdata", ar_wdata, 32'h1234_5678);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("abstractcs_busy", rd, 32'h0000_1001);
        check_val("ar_req_single", {31'h0, ar_req}, 32'h0);
        pulse_done(32'hDEAD_BEEF);
        dmi_xfer(2'd1, 7'h04, 32'h0, rd);
        check_val("data0_loaded", rd, 32'hDEAD_BEEF);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("abstractcs_done", rd, 32'h0000_0001);

        // command while busy -> cmderr busy, then ignored while cmderr set
        dmi_xfer(2'd2, 7'h17, 32'h0022_1001, rd);
        dmi_xfer(2'd2, 7'h17, 32'h0022_1002, rd);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("cmderr_busy", rd, 32'h0000_1101);
        pulse_done(32'h0BAD_F00D);
        dmi_xfer(2'd1, 7'h04, 32'h0, rd);
        check_val("data0_second", rd, 32'h0BAD_F00D);
        dmi_xfer(2'd2, 7'h17, 32'h0022_1001, rd);
        check_val("cmd_ignored_on_err", {31'h0, ar_req}, 32'h0);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("cmderr_sticky", rd, 32'h0000_0101);
        dmi_xfer(2'd2, 7'h16, 32'h0000_0700, rd);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("cmderr_w1c", rd, 32'h0000_0001);

        // unsupported cmdtype
        dmi_xfer(2'd2, 7'h17, 32'h0122_1001, rd);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("cmderr_notsup", rd, 32'h0000_0201);
        dmi_xfer(2'd2, 7'h16, 32'h0000_0700, rd);

        // transfer=0: no access, stays idle
        dmi_xfer(2'd2, 7'h17, 32'h0020_1001, rd);
        check_val("no_transfer_req", {31'h0, ar_req}, 32'h0);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("no_transfer_idle", rd, 32'h0000_0001);

        // hart not halted
        hart_halted = 1'b0;
        dmi_xfer(2'd2, 7'h17, 32'h0022_1001, rd);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("cmderr_haltresume", rd, 32'h0000_0401);
        dmi_xfer(2'd2, 7'h16, 32'h0000_0700, rd);

        // reset while waiting for ar_done, then a late ar_done
        hart_halted = 1'b1;
        dmi_xfer(2'd2, 7'h17, 32'h0022_1001, rd);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        ar_done = 1'b1; ar_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1; ar_done = 1'b0; ar_rdata = 32'h0;
        check_reset_outputs("post_reset");
        dmi_xfer(2'd2, 7'h10, 32'h0000_0001, rd);
        dmi_xfer(2'd1, 7'h16, 32'h0, rd);
        check_val("post_reset_abstractcs", rd, 32'h0000_0001);
        dmi_xfer(2'd1, 7'h04, 32'h0, rd);
        check_val("post_reset_data0", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
